udp_frame_launcher: RTL and testbench
=====================================

// Module: udp_frame_launcher
// PURPOSE
// Consumes the decoded control fields (start_udp_o, host, dst, packet) of the S2M control-register stage.
// On a fresh start request it emits a burst of 'packet' UDP test frames as AXI-Stream beats to the UDP TX path.
// Each frame is one header beat, then PAYLOAD_BEATS payload beats. Frames are separated by IFG_CYCLES idle cycles.
// Runs entirely in the m_aclk domain.
// PARAMETERS
// DATA_WIDTH     32  stream width; must be >= 32; bits above [31:0] are driven 0
// PAYLOAD_BEATS  8   payload beats per frame, 1..65535
// IFG_CYCLES     4   idle cycles between frames, 0..255; 0 = back-to-back
// PORTS
// m_aclk         in   1           clock
// rst            in   1           synchronous, active-high reset
// start_udp_i    in   1           start level from the control-register stage
// host           in   4           source host id
// dst            in   4           destination id
// packet         in   4           frames per burst; 0 = no frames
// m_axis_tdata   out  DATA_WIDTH  stream data
// m_axis_tvalid  out  1           stream valid
// m_axis_tready  in   1           stream ready
// m_axis_tlast   out  1           last beat of a frame
// busy           out  1           high in every state except IDLE
// done           out  1           one-cycle pulse when a burst completes
// frame_count    out  16          only with UDP_TX_STATS_EN
// BEHAVIOUR
// - Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, frame_count=0, state=IDLE.
// - start_d is a register of start_udp_i and resets to 1. A level held high through reset therefore never launches.
// - launch = start_udp_i & ~start_d. It is honoured only in IDLE; launches in any other state are dropped, not queued.
// - On launch, host/dst/packet are latched and the frame sequence counter seq is cleared to 0. Input changes after launch are ignored.
// - Latency: if launch is true at edge N, tvalid is high in the cycle after edge N.
// - States and transitions:
//     IDLE    -> HDR   on launch with packet != 0
//     IDLE    -> DONE  on launch with packet == 0
//     HDR     -> PAY   on the header handshake
//     PAY     -> GAP   on the tlast handshake, if seq+1 < packet and IFG_CYCLES > 0
//     PAY     -> HDR   on the tlast handshake, if seq+1 < packet and IFG_CYCLES == 0
//     PAY     -> DONE  on the tlast handshake of the last frame
//     GAP     -> HDR   after IFG_CYCLES cycles with tvalid=0
//     DONE    -> IDLE  after one cycle, with done=1 for that cycle
// - seq increments on each tlast handshake.
// - Header beat tdata[31:0] = {16'hCAFE, seq[3:0], packet, dst, host}; tlast=0.
// - Payload beat k (k = 0..PAYLOAD_BEATS-1): tdata[31:0] = {12'h0, seq[3:0], k[15:0]}; tlast=1 only on k = PAYLOAD_BEATS-1.
// - AXIS rules:
//     - A beat transfers on tvalid & tready.
//     - While tvalid & ~tready, tdata and tlast are held stable.
//     - tvalid is never deasserted before its handshake, except by rst.
// - rst mid-burst: the next edge forces IDLE and tvalid=0. The frame is truncated with no tlast guarantee. The next launch starts again at seq 0.
// - A simultaneous launch and rst: rst wins.
// CONFIGURATION
// - UDP_TX_STATS_EN defined:
//     - frame_count port is present.
//     - It increments on every tlast handshake and wraps 0xFFFF -> 0x0000.
//     - It is cleared only by rst, not by launch.
// - UDP_TX_STATS_EN undefined: port and counter are absent. All other behaviour is identical.
// TESTING
// 1. Hold start_udp_i=1 through rst release -> no tvalid for 50 cycles, busy=0. Then drop and re-raise start_udp_i -> burst starts.
// 2. Defaults, host=3, dst=5, packet=2, tready=1 -> header 0xCAFE0253, payload 0x00000000..0x00000007 (tlast on 7), 4 idle cycles,
//    header 0xCAFE1253, payload 0x00010000..0x00010007, exactly one done pulse; with stats, frame_count=2.
// 3. Test 2 with tready randomly toggled 50% -> identical beat sequence; tdata/tlast never change while stalled.
// 4. packet=0 launch -> done=1 exactly one cycle after launch, tvalid never asserted.
// 5. Second start edge during a burst (packet=3) -> ignored, exactly 3 frames; a new edge after done -> a new burst at seq 0.
// 6. rst asserted on payload beat 4 of frame 1 -> tvalid=0 and busy=0 after the edge. The next launch starts with header seq=0.

Source files
------------

// File: rtl/udp_frame_launcher.sv
// Burst generator: on a start edge, emits 'packet' UDP test frames (header + payload beats) on AXI-Stream.
// Optional frame counter output enabled by defining UDP_TX_STATS_EN.
module udp_frame_launcher #(
   parameter int DATA_WIDTH    = 32,
   parameter int PAYLOAD_BEATS = 8,
   parameter int IFG_CYCLES    = 4
) (
   input  logic                  m_aclk,
   input  logic                  rst,
   input  logic                  start_udp_i,
   input  logic [3:0]            host,
   input  logic [3:0]            dst,
   input  logic [3:0]            packet,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done
`ifdef UDP_TX_STATS_EN
   ,
   output logic [15:0]           frame_count
`endif
);

   // state | meaning
   // IDLE  | waiting for a start edge
   // HDR   | header beat presented
   // PAY   | payload beats presented
   // GAP   | inter-frame idle, gap timer counting down
   // DONE  | one-cycle done pulse
   typedef enum logic [2:0] {IDLE, HDR, PAY, GAP, DONE} state_t;

   localparam logic [15:0] LAST_BEAT = 16'(PAYLOAD_BEATS - 1);
   localparam logic [7:0]  GAP_LOAD  = 8'(IFG_CYCLES - 1);

   state_t                state_q, state_d;
   logic                  start_prev_q, start_prev_d;
   logic [3:0]            host_q, host_d, dst_q, dst_d, pkt_q, pkt_d, seq_q, seq_d;
   logic [15:0]           beat_q, beat_d;
   logic [7:0]            gap_q, gap_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  launch, hs;
   logic [4:0]            seq_inc;
   logic [15:0]           beat_inc;

   function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [3:0] s, input logic [3:0] p,
                                                      input logic [3:0] d, input logic [3:0] h);
      hdr_word        = '0;
      hdr_word[31:0]  = {16'hCAFE, s, p, d, h};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pay_word(input logic [3:0] s, input logic [15:0] k);
      pay_word        = '0;
      pay_word[31:0]  = {12'h000, s, k};
   endfunction

   assign launch   = start_udp_i & ~start_prev_q;
   assign hs       = tvalid_q & m_axis_tready;
   assign seq_inc  = {1'b0, seq_q} + 5'd1;
   assign beat_inc = beat_q + 16'd1;

   always_comb begin
      state_d      = state_q;
      start_prev_d = start_udp_i;
      host_d       = host_q;
      dst_d        = dst_q;
      pkt_d        = pkt_q;
      seq_d        = seq_q;
      beat_d       = beat_q;
      gap_d        = gap_q;
      tvalid_d     = tvalid_q;
      tlast_d      = tlast_q;
      tdata_d      = tdata_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               host_d = host;
               dst_d  = dst;
               pkt_d  = packet;
               seq_d  = 4'd0;
               busy_d = 1'b1;
               if (packet != 4'd0) begin
                  state_d  = HDR;
                  tvalid_d = 1'b1;
                  tlast_d  = 1'b0;
                  tdata_d  = hdr_word(4'd0, packet, dst, host);
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         HDR: begin
            if (hs) begin
               state_d = PAY;
               beat_d  = 16'd0;
               tdata_d = pay_word(seq_q, 16'd0);
               tlast_d = (LAST_BEAT == 16'd0);
            end
         end
         PAY: begin
            if (hs) begin
               if (tlast_q) begin
                  seq_d   = seq_inc[3:0];
                  tlast_d = 1'b0;
                  if (seq_inc < {1'b0, pkt_q}) begin
                     if (IFG_CYCLES > 0) begin
                        state_d  = GAP;
                        tvalid_d = 1'b0;
                        gap_d    = GAP_LOAD;
                     end else begin
                        state_d = HDR;
                        tdata_d = hdr_word(seq_inc[3:0], pkt_q, dst_q, host_q);
                     end
                  end else begin
                     state_d  = DONE;
                     tvalid_d = 1'b0;
                     done_d   = 1'b1;
                  end
               end else begin
                  beat_d  = beat_inc;
                  tdata_d = pay_word(seq_q, beat_inc);
                  tlast_d = (beat_inc == LAST_BEAT);
               end
            end
         end
         GAP: begin
            // gap timer is a down-counter; terminal count hands over to the next header
            if (gap_q == 8'd0) begin
               state_d  = HDR;
               tvalid_d = 1'b1;
               tdata_d  = hdr_word(seq_q, pkt_q, dst_q, host_q);
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_aclk) begin
      if (rst) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b1;   // a level held through reset is not an edge
         host_q       <= '0;
         dst_q        <= '0;
         pkt_q        <= '0;
         seq_q        <= '0;
         beat_q       <= '0;
         gap_q        <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tdata_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         host_q       <= host_d;
         dst_q        <= dst_d;
         pkt_q        <= pkt_d;
         seq_q        <= seq_d;
         beat_q       <= beat_d;
         gap_q        <= gap_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         tdata_q      <= tdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef UDP_TX_STATS_EN
   logic [15:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      if (hs && tlast_q) frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge m_aclk) begin
      if (rst) frame_count_q <= '0;
      else     frame_count_q <= frame_count_d;
   end

   assign frame_count = frame_count_q;
`endif

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_udp_frame_launcher.sv
// Directed bench for udp_frame_launcher: expected beats are queued at launch and popped on each handshake.
// Define UDP_TX_STATS_EN to also exercise frame_count.
module tb_udp_frame_launcher;
   localparam int DW  = 32;
   localparam int PB  = 8;
   localparam int IFG = 4;

   logic          m_aclk = 1'b0;
   logic          rst = 1'b1;
   logic          start_udp_i = 1'b1;
   logic [3:0]    host = '0, dst = '0, packet = '0;
   logic [DW-1:0] tdata;
   logic          tvalid, tlast, busy, done;
   logic          tready = 1'b1;
`ifdef UDP_TX_STATS_EN
   logic [15:0]   frame_count;
`endif

   int            checks = 0, errors = 0;
   logic [32:0]   exp_q[$];
   int            valid_cnt = 0, done_cnt = 0, gap_cnt = 0;
   bit            rand_ready = 1'b0;
   bit            held = 1'b0;
   logic [32:0]   held_val;

   udp_frame_launcher #(.DATA_WIDTH(DW), .PAYLOAD_BEATS(PB), .IFG_CYCLES(IFG)) dut (
      .m_aclk(m_aclk), .rst(rst), .start_udp_i(start_udp_i),
      .host(host), .dst(dst), .packet(packet),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .busy(busy), .done(done)
`ifdef UDP_TX_STATS_EN
      , .frame_count(frame_count)
`endif
   );

   initial forever #5 m_aclk = ~m_aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge m_aclk);
   endtask

   // ready changes just after each rising edge so it is stable at the next one
   initial forever begin
      @(posedge m_aclk);
      #1;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial forever begin
      @(negedge m_aclk);
      if (rst) begin
         held = 1'b0;
      end else begin
         if (tvalid) valid_cnt++;
         if (done) done_cnt++;
         if (busy && !tvalid && !done) gap_cnt++;
         if (held) check("stall_hold", {tvalid, tlast, tdata}, {1'b1, held_val});
         held = 1'b0;
         if (tvalid && !tready) begin
            held     = 1'b1;
            held_val = {tlast, tdata};
         end
         if (tvalid && tready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("beat", {tlast, tdata}, exp_q.pop_front());
         end
      end
   end

   task automatic push_burst(input logic [3:0] h, input logic [3:0] d, input logic [3:0] p);
      for (int f = 0; f < int'(p); f++) begin
         exp_q.push_back({1'b0, 16'hCAFE, 4'(f), p, d, h});
         for (int k = 0; k < PB; k++)
            exp_q.push_back({k == PB - 1, 12'h000, 4'(f), 16'(k)});
      end
   endtask

   task automatic launch(input logic [3:0] h, input logic [3:0] d, input logic [3:0] p);
      @(negedge m_aclk);
      start_udp_i = 1'b0;
      @(negedge m_aclk);
      host        = h;
      dst         = d;
      packet      = p;
      start_udp_i = 1'b1;
      push_burst(h, d, p);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge m_aclk);
         n++;
      end
      check({tag, "_done_seen"}, done_cnt != d0, 1);
      cycles(3);
      check({tag, "_one_done"}, done_cnt - d0, 1);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_all_beats"}, exp_q.size(), 0);
   endtask

   initial begin
      int v0, g0, n;

      // start held high through reset must not launch
      cycles(3);
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef UDP_TX_STATS_EN
      check("rst_frame_count", frame_count, 0);
`endif
      rst = 1'b0;
      v0  = valid_cnt;
      cycles(50);
      check("held_start_no_valid", valid_cnt - v0, 0);
      check("held_start_busy", busy, 0);

      // basic two-frame burst
      g0 = gap_cnt;
      launch(4'd3, 4'd5, 4'd2);
      @(negedge m_aclk);
      check("launch_latency_tvalid", tvalid, 1);
      check("launch_busy", busy, 1);
      check("first_header", tdata, 32'hCAFE0253);
      wait_done("burst2", 200);
      check("burst2_gap_cycles", gap_cnt - g0, IFG);
`ifdef UDP_TX_STATS_EN
      check("burst2_frame_count", frame_count, 2);
`endif

      // same burst under random backpressure
      rand_ready = 1'b1;
      g0 = gap_cnt;
      launch(4'd3, 4'd5, 4'd2);
      wait_done("burst2_stall", 1000);
      check("burst2_stall_gap_cycles", gap_cnt - g0, IFG);
      rand_ready = 1'b0;

      // zero-frame launch
      v0 = valid_cnt;
      launch(4'd1, 4'd2, 4'd0);
      @(negedge m_aclk);
      check("zero_pkt_done", done, 1);
      @(negedge m_aclk);
      check("zero_pkt_done_pulse", done, 0);
      cycles(2);
      check("zero_pkt_no_valid", valid_cnt - v0, 0);
      check("zero_pkt_idle", busy, 0);

      // second edge mid-burst is dropped
      g0 = gap_cnt;
      launch(4'd4, 4'd6, 4'd3);
      cycles(20);
      check("mid_burst_busy", busy, 1);
      start_udp_i = 1'b0;
      @(negedge m_aclk);
      host        = 4'd9;
      packet      = 4'd1;
      start_udp_i = 1'b1;
      wait_done("burst3", 600);
      check("burst3_gap_cycles", gap_cnt - g0, 2 * IFG);
      v0 = valid_cnt;
      cycles(10);
      check("no_queued_launch", valid_cnt - v0, 0);
      launch(4'd1, 4'd2, 4'd1);
      wait_done("burst_after", 200);

      // reset in the middle of frame 1 payload
      launch(4'd3, 4'd5, 4'd2);
      n = 0;
      while (!(tvalid && tdata == 32'h00010003) && n < 300) begin
         @(negedge m_aclk);
         n++;
      end
      check("reached_f1_beat3", tvalid && tdata == 32'h00010003, 1);
      @(posedge m_aclk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      cycles(2);
      check("mid_rst_tvalid", tvalid, 0);
      check("mid_rst_busy", busy, 0);
`ifdef UDP_TX_STATS_EN
      check("mid_rst_frame_count", frame_count, 0);
`endif
      rst = 1'b0;
      launch(4'd3, 4'd5, 4'd1);
      @(negedge m_aclk);
      check("post_rst_header_seq0", tdata, 32'hCAFE0153);
      wait_done("post_rst", 200);
`ifdef UDP_TX_STATS_EN
      check("post_rst_frame_count", frame_count, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
